cnet_prog_sequencer: RTL

CNET_PROG_SEQUENCER -- requirements
Module: cnet_prog_sequencer

---
 rtl/cnet_prog_pkg.sv | 33 +++
 rtl/cnet_prog_sequencer_if.sv | 41 ++++
 rtl/cnet_prog_timer.sv | 26 ++
 rtl/cnet_prog_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cnet_prog_pkg.sv
// Shared definitions for the partial-reconfiguration programming sequencer:
// state encoding, failure codes and default parameter values.
package cnet_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_INIT = 3'd2,
        ST_STREAM    = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_PASS      = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_BAD_LEN  = 3'd1;
    localparam logic [2:0] FC_ABORT    = 3'd2;
    localparam logic [2:0] FC_INIT_TO  = 3'd3;
    localparam logic [2:0] FC_OVERFLOW = 3'd4;
    localparam logic [2:0] FC_ERROR    = 3'd5;
    localparam logic [2:0] FC_DONE_TO  = 3'd6;

    localparam int DEF_RESET_CYCLES = 8;
    localparam int DEF_MIN_GAP      = 4;
    localparam int DEF_INIT_TIMEOUT = 1024;
    localparam int DEF_DONE_TIMEOUT = 65535;
    localparam int DEF_CNT_W        = 19;

    // Shared timer is reused for RESET length and both timeouts.
    localparam int TMR_W = 16;
    localparam int GAP_W = 4;

endpackage

// File: rtl/cnet_prog_sequencer_if.sv
// Host/datapath bundle of the programming sequencer; slave is the sequencer side.
interface cnet_prog_sequencer_if
    import cnet_prog_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] word_count;
    logic [31:0]      src_data;
    logic             src_vld;
    logic             src_rdy;
    logic [31:0]      prog_data;
    logic             prog_data_vld;
    logic             prog_reset;
    logic             cnet_reprog;
    logic             overflow;
    logic             error;
    logic             init;
    logic             done;
    logic             busy;
    logic             pass;
    logic             fail;
    logic [2:0]       fail_code;
    logic [CNT_W-1:0] words_sent;

    modport slave (
        input  start, abort, word_count, src_data, src_vld,
               cnet_reprog, overflow, error, init, done,
        output src_rdy, prog_data, prog_data_vld, prog_reset,
               busy, pass, fail, fail_code, words_sent
    );

    modport master (
        output start, abort, word_count, src_data, src_vld,
               cnet_reprog, overflow, error, init, done,
        input  src_rdy, prog_data, prog_data_vld, prog_reset,
               busy, pass, fail, fail_code, words_sent
    );

endinterface

// File: rtl/cnet_prog_timer.sv
// Loadable down-counter with zero flag; load wins over decrement, stops at zero.
module cnet_prog_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/cnet_prog_sequencer.sv
// Programming sequencer: reset, init wait, paced word streaming and completion check.
// Define CNET_PROG_TIMEOUT_EN to enable the WAIT_INIT / WAIT_DONE timeouts.
module cnet_prog_sequencer
    import cnet_prog_pkg::*;
#(
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int MIN_GAP      = DEF_MIN_GAP,
    parameter int INIT_TIMEOUT = DEF_INIT_TIMEOUT,
    parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    cnet_prog_sequencer_if.slave bus
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   r_words_sent;
    logic [31:0]        r_prog_data;
    logic               r_prog_data_vld;
    logic [2:0]         r_fail_code;
    logic [2:0]         w_fail_code_nxt;
    logic               w_busy;
    logic               w_nxt_busy;
    logic               w_start;
    logic               w_src_rdy;
    logic               w_hs;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_zero;
    logic               w_gap_zero;
    logic [GAP_W-1:0]   w_gap_val;

    assign w_busy     = r_state inside {ST_RESET, ST_WAIT_INIT, ST_STREAM, ST_WAIT_DONE};
    assign w_nxt_busy = w_state_nxt inside {ST_RESET, ST_WAIT_INIT, ST_STREAM, ST_WAIT_DONE};
    assign w_start    = !w_busy && bus.start;
    assign w_src_rdy  = (r_state == ST_STREAM) && w_gap_zero && (r_remaining != '0);
    // A word offered in a cycle that leaves STREAM for FAIL is not taken.
    assign w_hs       = bus.src_vld && w_src_rdy && !bus.abort && !bus.overflow && !bus.error;
    assign w_gap_val  = w_hs ? GAP_W'(MIN_GAP - 1) : '0;

    always_comb begin
        w_state_nxt     = r_state;
        w_fail_code_nxt = r_fail_code;
        w_tmr_load      = 1'b0;
        w_tmr_val       = '0;
        case (r_state)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (bus.start) begin
                    if (bus.word_count != '0) begin
                        w_state_nxt     = ST_RESET;
                        w_fail_code_nxt = FC_NONE;
                        w_tmr_load      = 1'b1;
                        w_tmr_val       = TMR_W'(RESET_CYCLES - 1);
                    end else begin
                        w_state_nxt     = ST_FAIL;
                        w_fail_code_nxt = FC_BAD_LEN;
                    end
                end
            end
            ST_RESET: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_WAIT_INIT;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TMR_W'(INIT_TIMEOUT - 1);
                end
            end
            ST_WAIT_INIT: begin
                if (!bus.init) begin
                    w_state_nxt = ST_STREAM;
`ifdef CNET_PROG_TIMEOUT_EN
                end else if (w_tmr_zero) begin
                    w_state_nxt     = ST_FAIL;
                    w_fail_code_nxt = FC_INIT_TO;
`endif
                end
            end
            ST_STREAM: begin
                if (bus.overflow) begin
                    w_state_nxt     = ST_FAIL;
                    w_fail_code_nxt = FC_OVERFLOW;
                end else if (bus.error) begin
                    w_state_nxt     = ST_FAIL;
                    w_fail_code_nxt = FC_ERROR;
                end else if (r_remaining == '0) begin
                    w_state_nxt = ST_WAIT_DONE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TMR_W'(DONE_TIMEOUT - 1);
                end
            end
            ST_WAIT_DONE: begin
                if (bus.error) begin
                    w_state_nxt     = ST_FAIL;
                    w_fail_code_nxt = FC_ERROR;
                end else if (bus.done && !bus.cnet_reprog) begin
                    w_state_nxt = ST_PASS;
`ifdef CNET_PROG_TIMEOUT_EN
                end else if (w_tmr_zero) begin
                    w_state_nxt     = ST_FAIL;
                    w_fail_code_nxt = FC_DONE_TO;
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_busy && bus.abort) begin
            w_state_nxt     = ST_FAIL;
            w_fail_code_nxt = FC_ABORT;
            w_tmr_load      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_fail_code     <= FC_NONE;
            r_remaining     <= '0;
            r_words_sent    <= '0;
            r_prog_data     <= 32'hffff_ffff;
            r_prog_data_vld <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_fail_code     <= w_fail_code_nxt;
            r_prog_data_vld <= w_hs;
            if (w_start) begin
                r_remaining  <= bus.word_count;
                r_words_sent <= '0;
            end else if (w_hs) begin
                r_remaining  <= r_remaining - CNT_W'(1);
                r_words_sent <= r_words_sent + CNT_W'(1);
            end
            if (w_hs) begin
                r_prog_data <= bus.src_data;
            end else if (!w_nxt_busy) begin
                r_prog_data <= 32'hffff_ffff;
            end
        end
    end

    cnet_prog_timer #(.W(TMR_W)) u_tmo_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_busy && (r_state != ST_STREAM)),
        .o_zero     (w_tmr_zero)
    );

    cnet_prog_timer #(.W(GAP_W)) u_gap_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_hs || w_start),
        .i_load_val (w_gap_val),
        .i_dec      (r_state == ST_STREAM),
        .o_zero     (w_gap_zero)
    );

    assign bus.src_rdy       = w_src_rdy;
    assign bus.prog_data     = r_prog_data;
    assign bus.prog_data_vld = r_prog_data_vld;
    assign bus.prog_reset    = (r_state == ST_RESET);
    assign bus.busy          = w_busy;
    assign bus.pass          = (r_state == ST_PASS);
    assign bus.fail          = (r_state == ST_FAIL);
    assign bus.fail_code     = r_fail_code;
    assign bus.words_sent    = r_words_sent;

endmodule
